// File: rtl/pool_layer_ctrl_if.sv
// Bus bundle between the pool layer sequencer, the source/destination memories
// and the 2x2 max-pool unit.
//
// Handshake semantics: every channel here is strobe-only with no back-pressure.
// A strobe (src_rd_en, pool_in_valid, pool_out_valid, dst_wr_en) qualifies the
// address/data on the same cycle. The receiver must accept it on that cycle.
// src_rd_data answers a src_rd_en exactly one cycle later.
interface pool_layer_ctrl_if #(
  parameter int IN_AW  = 13,
  parameter int OUT_AW = 11
);
  logic              src_rd_en;
  logic [IN_AW-1:0]  src_addr;
  logic [7:0]        src_rd_data;

  logic              pool_clr_n;
  logic              pool_in_valid;
  logic [7:0]        pool_in_data;
  logic              pool_out_valid;
  logic [7:0]        pool_out_data;

  logic              dst_wr_en;
  logic [OUT_AW-1:0] dst_addr;
  logic [7:0]        dst_wr_data;

  modport master (
    output src_rd_en, src_addr,
    input  src_rd_data,
    output pool_clr_n, pool_in_valid, pool_in_data,
    input  pool_out_valid, pool_out_data,
    output dst_wr_en, dst_addr, dst_wr_data
  );

  modport slave (
    input  src_rd_en, src_addr,
    output src_rd_data,
    input  pool_clr_n, pool_in_valid, pool_in_data,
    output pool_out_valid, pool_out_data,
    input  dst_wr_en, dst_addr, dst_wr_data
  );
endinterface

// File: rtl/pool_layer_ctrl.sv
// Layer sequencer for the streaming 2x2 max-pool unit: per channel it clears the
// unit, streams one frame in raster order and writes the pooled results out.
module pool_layer_ctrl #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int NUM_CH    = 6,
  parameter int IN_AW     = 13,
  parameter int OUT_AW    = 11,
  parameter int DRAIN_MAX = 64,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CH_W-1:0]   ch_idx,
  output logic [2:0]        state_dbg,
  pool_layer_ctrl_if.master bus
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NOUT  = NPIX / 4;
  localparam int PIX_W = $clog2(NPIX);
  localparam int OUT_W = $clog2(NOUT + 1);
  localparam int DRN_W = $clog2(DRAIN_MAX + 1);

  localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(NPIX - 1);
  localparam logic [OUT_W-1:0]  OUT_FULL = OUT_W'(NOUT);
  localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(DRAIN_MAX);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [IN_AW-1:0]  NPIX_A   = IN_AW'(NPIX);
  localparam logic [OUT_AW-1:0] NOUT_A   = OUT_AW'(NOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state;
  logic [PIX_W-1:0]  pix_cnt;
  logic [OUT_W-1:0]  out_cnt;
  logic [DRN_W-1:0]  drain_cnt;
  logic [DRN_W-1:0]  drain_inc;
  logic [IN_AW-1:0]  src_base;
  logic [OUT_AW-1:0] dst_base;
  logic              wr_window;
  logic              out_full;

  assign state_dbg = state;
  assign drain_inc = drain_cnt + DRN_W'(1);
  assign wr_window = (state == S_STREAM) || (state == S_DRAIN);
  assign out_full  = (out_cnt == OUT_FULL);

  // Source data lands one cycle after the read strobe, aligned with pool_in_valid.
  assign bus.pool_in_data = bus.pool_in_valid ? bus.src_rd_data : 8'h00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      ch_idx            <= '0;
      pix_cnt           <= '0;
      out_cnt           <= '0;
      drain_cnt         <= '0;
      src_base          <= '0;
      dst_base          <= '0;
      bus.src_rd_en     <= 1'b0;
      bus.src_addr      <= '0;
      bus.pool_clr_n    <= 1'b1;
      bus.pool_in_valid <= 1'b0;
      bus.dst_wr_en     <= 1'b0;
      bus.dst_addr      <= '0;
      bus.dst_wr_data   <= '0;
    end else begin
      done              <= 1'b0;
      bus.pool_clr_n    <= 1'b1;
      bus.dst_wr_en     <= 1'b0;
      bus.pool_in_valid <= bus.src_rd_en;

      // Results outside the frame window are stale leftovers and are dropped silently.
      if (wr_window && bus.pool_out_valid) begin
        if (out_full) begin
          err <= 1'b1;
        end else begin
          bus.dst_wr_en   <= 1'b1;
          bus.dst_wr_data <= bus.pool_out_data;
          bus.dst_addr    <= dst_base + OUT_AW'(out_cnt);
          out_cnt         <= out_cnt + OUT_W'(1);
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_CLEAR;
            busy           <= 1'b1;
            err            <= 1'b0;
            ch_idx         <= '0;
            src_base       <= '0;
            dst_base       <= '0;
            bus.pool_clr_n <= 1'b0;
          end
        end
        S_CLEAR: begin
          pix_cnt       <= '0;
          out_cnt       <= '0;
          drain_cnt     <= '0;
          bus.src_rd_en <= 1'b1;
          bus.src_addr  <= src_base;
          state         <= S_STREAM;
        end
        S_STREAM: begin
          if (pix_cnt == PIX_LAST) begin
            bus.src_rd_en <= 1'b0;
            state         <= S_DRAIN;
          end else begin
            pix_cnt      <= pix_cnt + PIX_W'(1);
            bus.src_addr <= bus.src_addr + IN_AW'(1);
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_inc;
          if (out_full || (drain_inc == DRN_LAST)) begin
            if (!out_full) err <= 1'b1;
            if (ch_idx == CH_LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              ch_idx         <= ch_idx + CH_W'(1);
              src_base       <= src_base + NPIX_A;
              dst_base       <= dst_base + NOUT_A;
              bus.pool_clr_n <= 1'b0;
              state          <= S_CLEAR;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_layer_ctrl.sv
// Bench for pool_layer_ctrl: memories and a behavioural 2x2 max-pool unit
// (optionally dropping or adding a result), with golden writes from plain arithmetic.
module tb_pool_layer_ctrl;

  localparam int IMG_W     = 28;
  localparam int IMG_H     = 28;
  localparam int NUM_CH    = 2;
  localparam int IN_AW     = 13;
  localparam int OUT_AW    = 11;
  localparam int DRAIN_MAX = 64;
  localparam int NPIX      = IMG_W * IMG_H;
  localparam int NOUT      = NPIX / 4;
  localparam int CH_W      = 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic            start;
  logic            busy, done, err;
  logic [CH_W-1:0] ch_idx;
  logic [2:0]      state_dbg;

  pool_layer_ctrl_if #(.IN_AW(IN_AW), .OUT_AW(OUT_AW)) bus ();

  pool_layer_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_CH(NUM_CH),
    .IN_AW(IN_AW), .OUT_AW(OUT_AW), .DRAIN_MAX(DRAIN_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .err(err), .ch_idx(ch_idx), .state_dbg(state_dbg), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // source memory, 1-cycle read latency
  logic [7:0] src_mem [NUM_CH*NPIX];
  initial bus.src_rd_data = 8'h00;
  always @(posedge clk) if (bus.src_rd_en) bus.src_rd_data <= src_mem[bus.src_addr];

  // behavioural pool unit; pool_mode 0 = normal, 1 = drop last result, 2 = extra result
  int         pool_mode;
  logic [7:0] frame [NPIX];
  int         in_cnt, emitted;
  logic       extra_pend;

  function automatic logic [7:0] max4(input logic [7:0] a, b, c, d);
    logic [7:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  initial begin
    bus.pool_out_valid = 1'b0;
    bus.pool_out_data  = 8'h00;
  end

  always @(posedge clk) begin
    bus.pool_out_valid <= 1'b0;
    if (!rst_n || !bus.pool_clr_n) begin
      in_cnt     <= 0;
      emitted    <= 0;
      extra_pend <= 1'b0;
    end else begin
      if (extra_pend) begin
        bus.pool_out_valid <= 1'b1;
        bus.pool_out_data  <= 8'hEE;
        extra_pend         <= 1'b0;
      end
      if (bus.pool_in_valid && in_cnt < NPIX) begin
        frame[in_cnt] <= bus.pool_in_data;
        in_cnt        <= in_cnt + 1;
        if (((in_cnt / IMG_W) % 2 == 1) && ((in_cnt % IMG_W) % 2 == 1)) begin
          emitted <= emitted + 1;
          if (!(pool_mode == 1 && emitted == NOUT - 1)) begin
            bus.pool_out_valid <= 1'b1;
            bus.pool_out_data  <= max4(frame[in_cnt-IMG_W-1], frame[in_cnt-IMG_W],
                                       frame[in_cnt-1], bus.pool_in_data);
          end
          if (pool_mode == 2 && emitted == NOUT - 1) extra_pend <= 1'b1;
        end
      end
    end
  end

  // reference model: golden pooled value for channel c, output index q
  function automatic logic [7:0] golden(input int c, input int q);
    int x, y, p0;
    x  = q % (IMG_W / 2);
    y  = q / (IMG_W / 2);
    p0 = c * NPIX + (2 * y) * IMG_W + 2 * x;
    return max4(src_mem[p0], src_mem[p0+1], src_mem[p0+IMG_W], src_mem[p0+IMG_W+1]);
  endfunction

  // scoreboard
  logic [OUT_AW+7:0] exp_q[$];
  int wr_cnt, done_cnt, iv_run, drn_run;
  int iv_runs[$];
  int drn_runs[$];

  task automatic push_layer(input bit drop_last);
    for (int c = 0; c < NUM_CH; c++)
      for (int q = 0; q < NOUT - (drop_last ? 1 : 0); q++)
        exp_q.push_back({OUT_AW'(c * NOUT + q), golden(c, q)});
  endtask

  task automatic fill_src(input bit ramp);
    for (int c = 0; c < NUM_CH; c++)
      for (int p = 0; p < NPIX; p++)
        src_mem[c*NPIX+p] = ramp ? 8'((p + c) % 256) : 8'($urandom_range(0, 255));
  endtask

  task automatic clear_stats();
    wr_cnt = 0; done_cnt = 0;
    iv_runs.delete();
    drn_runs.delete();
  endtask

  always @(negedge clk) begin
    logic [OUT_AW+7:0] e;
    if (rst_n) begin
      if (!bus.pool_in_valid) check("in_data_idle_zero", bus.pool_in_data, 0);
      if (bus.dst_wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_addr", bus.dst_addr, e[8 +: OUT_AW]);
          check("wr_data", bus.dst_wr_data, e[7:0]);
        end
      end
      if (done) done_cnt++;
    end
    if (bus.pool_in_valid) iv_run++;
    else if (iv_run > 0) begin iv_runs.push_back(iv_run); iv_run = 0; end
    if (state_dbg == ST_DRAIN) drn_run++;
    else if (drn_run > 0) begin drn_runs.push_back(drn_run); drn_run = 0; end
  end

  // driver helpers
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    bit found = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done) begin found = 1; break; end
    end
    check({tag, "_done_seen"}, found, 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, state_dbg, ST_IDLE);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_ch_idx"}, ch_idx, 0);
    check({tag, "_src_rd_en"}, bus.src_rd_en, 0);
    check({tag, "_src_addr"}, bus.src_addr, 0);
    check({tag, "_pool_clr_n"}, bus.pool_clr_n, 1);
    check({tag, "_pool_in_valid"}, bus.pool_in_valid, 0);
    check({tag, "_pool_in_data"}, bus.pool_in_data, 0);
    check({tag, "_dst_wr_en"}, bus.dst_wr_en, 0);
    check({tag, "_dst_addr"}, bus.dst_addr, 0);
    check({tag, "_dst_wr_data"}, bus.dst_wr_data, 0);
  endtask

  task automatic check_runs(input string tag, input int n_layers);
    check({tag, "_iv_run_count"}, iv_runs.size(), NUM_CH * n_layers);
    foreach (iv_runs[i]) check({tag, "_iv_run_len"}, iv_runs[i], NPIX);
  endtask

  initial begin
    bit seen;
    iv_run = 0; drn_run = 0;
    rst_n = 1'b0; start = 1'b0; pool_mode = 0;
    clear_stats();
    fill_src(1'b1);
    repeat (3) step();
    check_reset("reset_init");
    rst_n = 1'b1;
    step();

    // functional layer, ramp data, per-channel timing from the start edge
    push_layer(1'b0);
    pulse_start();
    check("t1_state_clear", state_dbg, ST_CLEAR);
    check("t1_busy", busy, 1);
    check("t1_pool_clr_n", bus.pool_clr_n, 0);
    check("t1_src_rd_en", bus.src_rd_en, 0);
    step();
    check("t2_src_rd_en", bus.src_rd_en, 1);
    check("t2_src_addr", bus.src_addr, 0);
    check("t2_pool_in_valid", bus.pool_in_valid, 0);
    step();
    check("t3_pool_in_valid", bus.pool_in_valid, 1);
    check("t3_pool_in_data", bus.pool_in_data, src_mem[0]);
    run_until_done("func", 4000);
    check("func_done_busy", busy, 1);
    check("func_done_ch", ch_idx, NUM_CH - 1);
    step();
    check("func_idle_busy", busy, 0);
    check("func_idle_done", done, 0);
    repeat (3) step();
    check("func_done_count", done_cnt, 1);
    check("func_err", err, 0);
    check("func_wr_count", wr_cnt, NUM_CH * NOUT);
    check("func_exp_left", exp_q.size(), 0);
    check_runs("func", 1);
    foreach (drn_runs[i]) check("func_drain_short", drn_runs[i] < DRAIN_MAX, 1);

    // start pulses mid-STREAM and during DONE are ignored
    fill_src(1'b0);
    clear_stats();
    push_layer(1'b0);
    pulse_start();
    repeat ($urandom_range(50, 400)) step();
    check("ign_mid_state", state_dbg, ST_STREAM);
    pulse_start();
    check("ign_mid_still_stream", state_dbg, ST_STREAM);
    run_until_done("ign", 4000);
    pulse_start();
    check("ign_done_to_idle", state_dbg, ST_IDLE);
    repeat (5) step();
    check("ign_busy", busy, 0);
    check("ign_done_count", done_cnt, 1);
    check("ign_wr_count", wr_cnt, NUM_CH * NOUT);
    check("ign_exp_left", exp_q.size(), 0);

    // start held high restarts on the first IDLE cycle
    fill_src(1'b0);
    clear_stats();
    push_layer(1'b0);
    push_layer(1'b0);
    start = 1'b1;
    run_until_done("held1", 4000);
    step();
    check("held_idle_state", state_dbg, ST_IDLE);
    check("held_idle_busy", busy, 0);
    step();
    check("held_restart_state", state_dbg, ST_CLEAR);
    check("held_restart_busy", busy, 1);
    start = 1'b0;
    run_until_done("held2", 4000);
    repeat (3) step();
    check("held_done_count", done_cnt, 2);
    check("held_wr_count", wr_cnt, 2 * NUM_CH * NOUT);
    check("held_exp_left", exp_q.size(), 0);
    check("held_err", err, 0);
    check_runs("held", 2);

    // missing last result per channel -> DRAIN timeout
    pool_mode = 1;
    fill_src(1'b0);
    clear_stats();
    push_layer(1'b1);
    pulse_start();
    run_until_done("miss", 4000);
    repeat (3) step();
    check("miss_err", err, 1);
    check("miss_done_count", done_cnt, 1);
    check("miss_wr_count", wr_cnt, NUM_CH * (NOUT - 1));
    check("miss_exp_left", exp_q.size(), 0);
    check("miss_drain_count", drn_runs.size(), NUM_CH);
    foreach (drn_runs[i]) check("miss_drain_len", drn_runs[i], DRAIN_MAX);
    check_runs("miss", 1);

    // one excess result per channel -> suppressed write, err set; start clears err
    pool_mode = 2;
    fill_src(1'b0);
    clear_stats();
    push_layer(1'b0);
    pulse_start();
    check("exc_err_cleared", err, 0);
    run_until_done("exc", 4000);
    repeat (3) step();
    check("exc_err", err, 1);
    check("exc_wr_count", wr_cnt, NUM_CH * NOUT);
    check("exc_exp_left", exp_q.size(), 0);
    check("exc_done_count", done_cnt, 1);

    // reset mid-STREAM of channel 1, then a clean layer
    pool_mode = 0;
    fill_src(1'b0);
    clear_stats();
    push_layer(1'b0);
    pulse_start();
    seen = 0;
    for (int i = 0; i < 4000; i++) begin
      if (ch_idx == 1 && state_dbg == ST_STREAM) begin seen = 1; break; end
      step();
    end
    check("rst_reached_ch1", seen, 1);
    repeat ($urandom_range(10, 600)) step();
    rst_n = 1'b0;
    step();
    check_reset("reset_mid_1");
    step();
    check_reset("reset_mid_2");
    exp_q.delete();
    rst_n = 1'b1;
    step();
    clear_stats();
    fill_src(1'b0);
    push_layer(1'b0);
    pulse_start();
    run_until_done("post_rst", 4000);
    repeat (3) step();
    check("post_rst_err", err, 0);
    check("post_rst_wr_count", wr_cnt, NUM_CH * NOUT);
    check("post_rst_exp_left", exp_q.size(), 0);
    check("post_rst_done_count", done_cnt, 1);
    check_runs("post_rst", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/pool_layer_ctrl.md
# pool_layer_ctrl

Layer-level sequencer for the streaming 2x2 max-pooling unit. On `start` it walks `NUM_CH` feature maps. For each channel it:
- clears the pool unit;
- streams `IMG_W*IMG_H` pixels from the source feature-map memory into it in raster order;
- collects the `(IMG_W/2)*(IMG_H/2)` pooled results and writes them to the destination memory.

It sits between the conv-layer output buffer and the next layer's input buffer and owns the pool unit's `in_valid`/`in_data` and per-frame clear.

## Interface
- `IMG_W`, 28, input frame width (even)
- `IMG_H`, 28, input frame height (even)
- `NUM_CH`, 6, channels processed per `start`
- `IN_AW`, 13, source address width (≥ clog2(NUM_CH*IMG_W*IMG_H))
- `OUT_AW`, 11, destination address width (≥ clog2(NUM_CH*IMG_W*IMG_H/4))
- `DRAIN_MAX`, 64, cycles allowed in DRAIN before timeout
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  begin layer; sampled only in IDLE
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at layer end
- `err`  out  1  sticky error flag (timeout/excess output); cleared on accepted `start`
- `ch_idx`  out  clog2(NUM_CH) (min 1)  current channel
- `src_rd_en`  out  1  source read strobe; data returns exactly 1 cycle later
- `src_addr`  out  IN_AW  `ch*IMG_W*IMG_H + pix`
- `src_rd_data`  in  8  source read data
- `pool_clr_n`  out  1  active-low per-frame clear; top level ANDs with `rst_n` into the pool unit's `rst_n`
- `pool_in_valid`  out  1  to pool unit `in_valid`
- `pool_in_data`  out  8  to pool unit `in_data`
- `pool_out_valid`  in  1  from pool unit `out_valid`
- `pool_out_data`  in  8  from pool unit `out_data`
- `dst_wr_en`  out  1  destination write strobe
- `dst_addr`  out  OUT_AW  `ch*(IMG_W/2)*(IMG_H/2) + q`
- `dst_wr_data`  out  8  pooled value

## Operation

**Derived constants:** `NPIX = IMG_W*IMG_H`, `NOUT = NPIX/4`.

**FSM states:** IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE: wait for `start=1` → clear `err`, set `ch_idx=0`, go to CLEAR.
- CLEAR: one cycle with `pool_clr_n=0`; `pix_cnt=0`, `out_cnt=0`, `drain_cnt=0` → STREAM.
- STREAM:
  - `src_rd_en=1` every cycle, `src_addr = ch*NPIX + pix_cnt`, `pix_cnt++`.
  - On the cycle issuing `pix_cnt=NPIX-1` → DRAIN.
  - Never stalls: read and feed are gap-free.
- Feed path:
  - `pool_in_valid` = `src_rd_en` delayed 1 cycle (register).
  - `pool_in_data` = `src_rd_data`, passed through combinationally; 0 when `pool_in_valid=0`.
- DRAIN:
  - `drain_cnt++` each cycle.
  - Exit when `out_cnt==NOUT` (normal) or `drain_cnt==DRAIN_MAX` (timeout: set `err`).
  - Then: if `ch_idx==NUM_CH-1` → DONE, else `ch_idx++` → CLEAR.
- DONE: `done=1` for one cycle → IDLE.

**Write path** (active in STREAM and DRAIN):
- Each `pool_out_valid=1` registers `dst_wr_en=1`, `dst_wr_data=pool_out_data`, `dst_addr=ch*NOUT+out_cnt` on the next cycle, then `out_cnt++`.
- If `out_cnt==NOUT` already: the write is suppressed and `err` is set.
- `pool_out_valid` in IDLE, CLEAR or DONE is ignored (no write, no `err`).

**Boundary conditions:**
- `start` outside IDLE is ignored, including during the DONE cycle.
- `start` held high through DONE→IDLE begins a new layer on the first IDLE cycle.
- `NUM_CH=1`: DRAIN → DONE directly.
- Counter widths are sized for their maxima; no wrap occurs within a layer.
- Reset mid-operation: all state and outputs return to reset values on the next edge; any in-flight read or write is discarded.

## Timing
- Reset values: state=IDLE, `busy=0`, `done=0`, `err=0`, `ch_idx=0`, `src_rd_en=0`, `src_addr=0`, `pool_clr_n=1`, `pool_in_valid=0`, `dst_wr_en=0`, `dst_addr=0`, `dst_wr_data=0`.
- Per-channel sequence, with `start` sampled at edge T:
  - CLEAR during cycle T+1 (`busy=1`, `pool_clr_n=0`).
  - `src_rd_en` high in cycles T+2 .. T+1+NPIX.
  - `pool_in_valid` high in cycles T+3 .. T+2+NPIX (NPIX consecutive cycles).
- Destination write: 1 cycle after each `pool_out_valid`.
- Channel period: 1 + NPIX + DRAIN length cycles.
- `done` rises the cycle after the final DRAIN exit; `busy` falls with entry to IDLE.

## Test plan
- **Reset:** hold `rst_n=0` 2 cycles after random activity → every output at its reset value; `pool_clr_n=1`.
- **Functional, real pool unit, `NUM_CH=2`:** `src[c*784+p]=(p+c)%256` → exactly 196 writes per channel; `dst[c*196+q]` matches the golden 2x2 max; `err=0`; exactly one `done`; 784 back-to-back `pool_in_valid` cycles per channel.
- **Start handling:** pulse `start` mid-STREAM and during DONE → ignored, no second layer; `start` held high → second layer starts immediately after IDLE entry.
- **Missing output:** stub pool emits only 195 results → DRAIN exits after 64 cycles; `err=1`; next channel still processed; `done` pulses.
- **Excess output:** stub emits a 197th `out_valid` → no write for it; `err=1`; write count stays 196.
- **Reset mid-operation:** assert `rst_n` mid-STREAM of channel 1 → outputs return to reset values; a fresh `start` completes correctly with `err=0`.
